tdm_mux_16_1: RTL and testbench
===============================

TDM_MUX_16_1 -- requirements
Module: tdm_mux_16_1

Interface
REQ-001 SHALL have parameter CHANNEL_HOLD_CYCLES, default 1, the number of clocks each channel is presented (legal 1..16).
REQ-002 SHALL have port Clock_In, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_In, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port Enable_In, input, 1; high = run, low = pause and tri-state the data output.
REQ-005 SHALL have port Data_In, input, 16, parallel channel data where bit i = channel i.
REQ-006 SHALL have port Capture_In, input, 1, a frame request that snapshots Data_In when accepted.
REQ-007 SHALL have port Mux_Data_Out, output, 1, the serialized channel bit.
REQ-008 SHALL have port Channel_Select_Out, output, 4, the index of the channel currently on Mux_Data_Out.
REQ-009 SHALL have port Valid_Out, output, 1, high while Mux_Data_Out carries frame data.
REQ-010 SHALL have port Frame_Start_Out, output, 1, a one-clock pulse on the first cycle of channel 0.
REQ-011 SHALL have port Frame_Done_Out, output, 1, a one-clock pulse on the last cycle of channel 15.
REQ-012 SHALL have port Busy_Out, output, 1, high in the SHIFT state.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SHIFT, plus a 16-bit frame register, a 4-bit channel counter and a hold counter sized for CHANNEL_HOLD_CYCLES.
REQ-014 IDLE: on an edge with Enable_In=1 and Capture_In=1, SHALL load the frame register from Data_In, zero both counters and enter SHIFT.
REQ-015 SHIFT with Enable_In=1: the hold counter SHALL increment each clock; on reaching CHANNEL_HOLD_CYCLES-1 it SHALL clear and the channel counter SHALL increment.
REQ-016 Channels SHALL be sent in order 0 to 15, with no gaps.
REQ-017 The frame SHALL last exactly 16*CHANNEL_HOLD_CYCLES enabled clocks, counted from the first cycle after the capture edge.
REQ-018 Last cycle (channel 15, hold = max), Capture_In=0: SHALL return to IDLE.
REQ-019 Last cycle, Capture_In=1: SHALL reload the frame register from Data_In, zero both counters and stay in SHIFT, giving back-to-back frames with zero idle cycles.
REQ-020 Capture_In asserted in SHIFT other than on the last cycle SHALL be ignored; the frame register SHALL be unchanged.
REQ-021 Mux_Data_Out SHALL equal frame_reg[Channel_Select_Out] in SHIFT, 0 in IDLE, and 1'bZ whenever Enable_In=0, independent of state.
REQ-022 Valid_Out SHALL equal Busy_Out AND Enable_In.
REQ-023 Frame_Start_Out SHALL be high when state=SHIFT, channel=0, hold=0 and Enable_In=1.
REQ-024 Frame_Done_Out SHALL be high when state=SHIFT, channel=15, hold=max and Enable_In=1.
REQ-025 Enable_In=0 SHALL freeze the state, both counters and the frame register; Capture_In SHALL be ignored.
REQ-026 Resuming with Enable_In=1 SHALL continue from the frozen channel and hold position.
REQ-027 Channel_Select_Out SHALL be 0 in IDLE.
REQ-028 Mux_Data_Out SHALL be a combinational function of registered state and Enable_In only, with no combinational path from Data_In.

Reset
REQ-029 Reset_In=1 at an edge SHALL force IDLE and clear the frame register and both counters, with priority over Enable_In and Capture_In.
REQ-030 After reset: Busy_Out=0, Valid_Out=0, Frame_Start_Out=0, Frame_Done_Out=0, Channel_Select_Out=0; Mux_Data_Out=0 if Enable_In=1, else Z.
REQ-031 Reset mid-frame SHALL abort the frame with no Frame_Done_Out; the next capture SHALL start a fresh frame at channel 0.

Verification
REQ-032 HOLD=1, Data_In=16'hA5C3, one Capture_In pulse -> next 16 clocks Mux_Data_Out = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with channel 0..15; Frame_Start_Out on clock 1, Frame_Done_Out on clock 16; Busy_Out=0 on clock 17.
REQ-033 HOLD=3, Data_In=16'h0001 -> channel 0 shows 1 for 3 clocks, channels 1..15 show 0 for 3 clocks each; 48-clock frame.
REQ-034 Capture_In held high, Data_In changed to 16'hFFFF mid-frame -> current frame unchanged; next frame starts immediately after Frame_Done_Out and all 16 bits read 1; Valid_Out never drops.
REQ-035 Enable_In low for 5 clocks at channel 7 -> Mux_Data_Out=Z, Valid_Out=0, Channel_Select_Out stays 7; on resume, channels 7..15 complete with a total of 16 enabled clocks.
REQ-036 Reset_In pulsed at channel 9 -> next clock Busy_Out=0, Channel_Select_Out=0, no Frame_Done_Out; a new capture produces a full 16-channel frame.

Source files
------------

// File: rtl/tdm_mux_16_1.sv
// 16:1 time-division multiplexer: snapshots a 16-bit frame on request and
// serializes it channel 0..15, holding each channel for CHANNEL_HOLD_CYCLES clocks.
module tdm_mux_16_1 #(
  parameter int CHANNEL_HOLD_CYCLES = 1
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Enable_In,
  input  logic [15:0] Data_In,
  input  logic        Capture_In,
  output logic        Mux_Data_Out,
  output logic [3:0]  Channel_Select_Out,
  output logic        Valid_Out,
  output logic        Frame_Start_Out,
  output logic        Frame_Done_Out,
  output logic        Busy_Out
);

  localparam int HOLD_W = (CHANNEL_HOLD_CYCLES > 1) ? $clog2(CHANNEL_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CHANNEL_HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       frame_q, frame_d;
  logic [3:0]        chan_q, chan_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic hold_wrap;
  logic last_cycle;
  logic mux_bit;

  assign hold_wrap  = (hold_q == HOLD_MAX);
  assign last_cycle = (state_q == SHIFT) && (chan_q == 4'd15) && hold_wrap;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    chan_d  = chan_q;
    hold_d  = hold_q;
    // Everything freezes while disabled, including capture requests.
    if (Enable_In) begin
      case (state_q)
        IDLE: begin
          if (Capture_In) begin
            frame_d = Data_In;
            chan_d  = 4'd0;
            hold_d  = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (last_cycle) begin
            chan_d = 4'd0;
            hold_d = '0;
            // A capture on the final cycle chains the next frame with no gap.
            if (Capture_In) frame_d = Data_In;
            else            state_d = IDLE;
          end else if (hold_wrap) begin
            hold_d = '0;
            chan_d = chan_q + 4'd1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      frame_q <= 16'd0;
      chan_q  <= 4'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      chan_q  <= chan_d;
      hold_q  <= hold_d;
    end
  end

  // Output bit depends only on registered state and Enable_In.
  assign mux_bit            = (state_q == SHIFT) ? frame_q[chan_q] : 1'b0;
  assign Mux_Data_Out       = Enable_In ? mux_bit : 1'bz;
  assign Busy_Out           = (state_q == SHIFT);
  assign Valid_Out          = Busy_Out && Enable_In;
  assign Channel_Select_Out = chan_q;
  assign Frame_Start_Out    = Valid_Out && (chan_q == 4'd0) && (hold_q == '0);
  assign Frame_Done_Out     = Valid_Out && last_cycle;

endmodule

// File: tb/tb_tdm_mux_16_1.sv
// Bench for tdm_mux_16_1: a HOLD=1 and a HOLD=3 instance, each checked every
// cycle against a frame-position model, plus hand-computed directed vectors.
module tb_tdm_mux_16_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, cap_a, rst_b, en_b, cap_b;
  logic [15:0] din_a, din_b;
  wire         mux_a, mux_b;
  logic [3:0]  chan_a, chan_b;
  logic        valid_a, start_a, done_a, busy_a;
  logic        valid_b, start_b, done_b, busy_b;

  tdm_mux_16_1 #(.CHANNEL_HOLD_CYCLES(1)) dut_a (
    .Clock_In(clk), .Reset_In(rst_a), .Enable_In(en_a), .Data_In(din_a),
    .Capture_In(cap_a), .Mux_Data_Out(mux_a), .Channel_Select_Out(chan_a),
    .Valid_Out(valid_a), .Frame_Start_Out(start_a), .Frame_Done_Out(done_a),
    .Busy_Out(busy_a)
  );

  tdm_mux_16_1 #(.CHANNEL_HOLD_CYCLES(3)) dut_b (
    .Clock_In(clk), .Reset_In(rst_b), .Enable_In(en_b), .Data_In(din_b),
    .Capture_In(cap_b), .Mux_Data_Out(mux_b), .Channel_Select_Out(chan_b),
    .Valid_Out(valid_b), .Frame_Start_Out(start_b), .Frame_Done_Out(done_b),
    .Busy_Out(busy_b)
  );

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Model: a frame is a position p counting enabled clocks 0..16*H-1.
  int          hcfg[2] = '{1, 3};
  bit          m_active[2];
  int          m_p[2];
  logic [15:0] m_bits[2];

  function automatic void model_step(int i, logic rst, logic en, logic cap, logic [15:0] din);
    int last;
    last = 16 * hcfg[i] - 1;
    if (rst) begin
      m_active[i] = 1'b0;
      m_p[i]      = 0;
      m_bits[i]   = 16'd0;
    end else if (en) begin
      if (!m_active[i]) begin
        if (cap) begin
          m_bits[i]   = din;
          m_p[i]      = 0;
          m_active[i] = 1'b1;
        end
      end else if (m_p[i] == last) begin
        m_p[i] = 0;
        if (cap) m_bits[i] = din;
        else     m_active[i] = 1'b0;
      end else begin
        m_p[i] = m_p[i] + 1;
      end
    end
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_a, en_a, cap_a, din_a);
    model_step(1, rst_b, en_b, cap_b, din_b);
  end

  // mux_code: 2 means high impedance, otherwise the bit value.
  function automatic void compare_inst(int i, logic en, int mux_code, logic [3:0] chan,
                                       logic valid, logic start, logic done, logic busy);
    int ch, exp_mux, last;
    string tag;
    tag  = (i == 0) ? "h1" : "h3";
    last = 16 * hcfg[i] - 1;
    ch   = m_active[i] ? (m_p[i] / hcfg[i]) : 0;
    if (!en)              exp_mux = 2;
    else if (m_active[i]) exp_mux = int'(m_bits[i][ch]);
    else                  exp_mux = 0;
    check({tag, "_mux"},   mux_code,   exp_mux);
    check({tag, "_chan"},  int'(chan), ch);
    check({tag, "_busy"},  int'(busy), int'(m_active[i]));
    check({tag, "_valid"}, int'(valid), int'(m_active[i] && en));
    check({tag, "_start"}, int'(start), int'(m_active[i] && en && m_p[i] == 0));
    check({tag, "_done"},  int'(done),  int'(m_active[i] && en && m_p[i] == last));
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      compare_inst(0, en_a, (mux_a === 1'bz) ? 2 : int'(mux_a), chan_a, valid_a, start_a, done_a, busy_a);
      compare_inst(1, en_b, (mux_b === 1'bz) ? 2 : int'(mux_b), chan_b, valid_b, start_b, done_b, busy_b);
    end
  end

  bit seq_a5c3[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
  bit seq_1234[16] = '{0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0};

  initial begin
    int cnt;
    bit seen_done;
    rst_a = 1'b1; en_a = 1'b1; cap_a = 1'b0; din_a = 16'd0;
    rst_b = 1'b1; en_b = 1'b1; cap_b = 1'b0; din_b = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0; chk_on = 1'b1;

    // Reset state, then tri-state while disabled in IDLE.
    @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_chan", int'(chan_a), 0);
    check("rst_mux",  (mux_a === 1'bz) ? 2 : int'(mux_a), 0);
    @(posedge clk); #1 en_a = 1'b0;
    @(negedge clk);
    check("rst_mux_z", (mux_a === 1'bz) ? 2 : int'(mux_a), 2);
    @(posedge clk); #1 en_a = 1'b1;

    // HOLD=1, 16'hA5C3 single frame.
    @(posedge clk); #1 din_a = 16'hA5C3; cap_a = 1'b1;
    @(posedge clk); #1 cap_a = 1'b0; din_a = 16'h0000;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("t1_mux",   int'(mux_a),   int'(seq_a5c3[k-1]));
      check("t1_chan",  int'(chan_a),  k - 1);
      check("t1_start", int'(start_a), int'(k == 1));
      check("t1_done",  int'(done_a),  int'(k == 16));
    end
    @(negedge clk);
    check("t1_busy_after", int'(busy_a), 0);

    // HOLD=3, 16'h0001: 48-clock frame.
    @(posedge clk); #1 din_b = 16'h0001; cap_b = 1'b1;
    @(posedge clk); #1 cap_b = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      check("t2_mux",   int'(mux_b),   int'(k <= 3));
      check("t2_chan",  int'(chan_b),  (k - 1) / 3);
      check("t2_start", int'(start_b), int'(k == 1));
      check("t2_done",  int'(done_b),  int'(k == 48));
    end
    @(negedge clk);
    check("t2_busy_after", int'(busy_b), 0);

    // Capture held high: mid-frame data change ignored, then back-to-back frame of ones.
    @(posedge clk); #1 din_a = 16'h1234; cap_a = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("t3_mux",   int'(mux_a),   (k <= 16) ? int'(seq_1234[k-1]) : 1);
      check("t3_valid", int'(valid_a), 1);
      check("t3_start", int'(start_a), int'(k == 1 || k == 17));
      check("t3_done",  int'(done_a),  int'(k == 16 || k == 32));
      if (k == 6)  din_a = 16'hFFFF;
      if (k == 17) cap_a = 1'b0;
    end
    @(negedge clk);
    check("t3_busy_after", int'(busy_a), 0);

    // Pause for 5 clocks at channel 7, then resume to completion.
    @(posedge clk); #1 din_a = 16'h3C80; cap_a = 1'b1;
    @(posedge clk); #1 cap_a = 1'b0;
    repeat (7) @(posedge clk);
    #1 en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_mux_z", (mux_a === 1'bz) ? 2 : int'(mux_a), 2);
      check("t4_valid", int'(valid_a), 0);
      check("t4_chan",  int'(chan_a), 7);
      cap_a = (k == 2);
    end
    cap_a = 1'b0;
    @(posedge clk); #1 en_a = 1'b1;
    cnt = 7;
    seen_done = 1'b0;
    for (int t = 0; t < 40 && !seen_done; t++) begin
      @(negedge clk);
      if (cnt == 7) check("t4_resume_mux", int'(mux_a), 1);
      if (valid_a) cnt++;
      if (done_a) begin
        seen_done = 1'b1;
        check("t4_done_chan", int'(chan_a), 15);
      end
    end
    check("t4_done_seen", int'(seen_done), 1);
    check("t4_enabled_clocks", cnt, 16);

    // Reset at channel 9 aborts the frame; a fresh capture gives a full frame.
    @(posedge clk); #1 din_a = 16'hBEEF; cap_a = 1'b1;
    @(posedge clk); #1 cap_a = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    @(negedge clk);
    check("t5_busy", int'(busy_a), 0);
    check("t5_chan", int'(chan_a), 0);
    check("t5_done", int'(done_a), 0);
    @(posedge clk); #1 din_a = 16'h00FF; cap_a = 1'b1;
    @(posedge clk); #1 cap_a = 1'b0;
    cnt = 0;
    seen_done = 1'b0;
    for (int t = 0; t < 40 && !seen_done; t++) begin
      @(negedge clk);
      if (valid_a) begin
        cnt++;
        if (cnt == 1) check("t5_first_start", int'(start_a), 1);
      end
      if (done_a) seen_done = 1'b1;
    end
    check("t5_done_seen", int'(seen_done), 1);
    check("t5_frame_len", cnt, 16);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
